muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide sequence. It raises a pipeline stall when a later instruction needs HI/LO or the unit while busy. It sits beside the datapath ALU, is enabled by the controller's decoded hi/lo signals, and feeds HI/LO back to the datapath for MFHI/MFLO.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/muldiv_negate.sv | 19 +
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------+
// | mips_pkg: shared mult/div encodings, sequencer states and sizing   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_CALC = 2'd1;
  localparam muldiv_state_t ST_FIX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/muldiv_negate.sv
// +--------------------------------------------------------------------+
// | muldiv_negate: conditional two's complement, y = neg ? -a : a      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +--------------------------------------------------------------------+
// | muldiv_unit: 32-step MULT/MULTU/DIV/DIVU sequencer owning HI/LO    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiuseD,
  input  logic             hienW,
  input  logic             loenW,
  input  logic [WIDTH-1:0] wdataW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallD
);

  localparam int CNT_W = $clog2(MULDIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITERS - 1);

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic               div_mode;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;

  // Operand decode and magnitudes at issue time
  logic             is_signed;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign is_signed = (opE == OP_MULT) || (opE == OP_DIV);
  assign is_div    = (opE == OP_DIV)  || (opE == OP_DIVU);
  assign sign_a    = is_signed & srcaE[WIDTH-1];
  assign sign_b    = is_signed & srcbE[WIDTH-1];
  assign div_zero  = is_div & (srcbE == '0);

  muldiv_negate #(.WIDTH(WIDTH)) u_mag_a (.neg(sign_a), .a(srcaE), .y(mag_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_mag_b (.neg(sign_b), .a(srcbE), .y(mag_b));

  // Multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: the partial remainder needs one extra bit
  // because it is shifted before the trial subtract.
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_part = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, opnd};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
  assign div_next = {div_rem, acc[WIDTH-2:0], div_ok};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_q), .a(acc), .y(prod_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q), .a(acc[WIDTH-1:0]), .y(quo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_r), .a(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));

  logic w_write;
  assign w_write = hienW | loenW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startE) begin
            div_mode <= is_div;
            // Divide by zero keeps the quotient at all ones; the remainder
            // correction by the dividend sign restores the raw dividend.
            neg_q    <= (sign_a ^ sign_b) & ~div_zero;
            neg_r    <= sign_a;
            acc      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd     <= is_div ? mag_b : mag_a;
            cnt      <= '0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= div_mode ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!w_write) begin
            hi <= div_mode ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo <= div_mode ? quo_fix : prod_fix[WIDTH-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A writeback MTHI/MTLO wins over any in-flight sequence
      if (w_write && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end
      if (hienW) hi <= wdataW;
      if (loenW) lo <= wdataW;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign stallD = busy & (startE | hiuseD);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_unit: directed vectors plus cycle-by-cycle reference     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0;
  logic [1:0]  opE = 2'b00;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        hiuseD = 1'b0;
  logic        hienW = 1'b0;
  logic        loenW = 1'b0;
  logic [31:0] wdataW = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stallD;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .hiuseD(hiuseD),
    .hienW(hienW), .loenW(loenW), .wdataW(wdataW),
    .hi(hi), .lo(lo), .busy(busy), .stallD(stallD)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic
  function automatic logic [63:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Reference: cycles remaining until the pending result lands
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi    <= '0;
      m_lo    <= '0;
      m_left  <= 0;
      m_valid <= 1'b1;
    end else begin
      if (m_left != 0) begin
        if (hienW | loenW) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
          end
        end
      end else if (startE) begin
        m_pend <= model_op(opE, srcaE, srcbE);
        m_left <= 33;
      end
      if (hienW) m_hi <= wdataW;
      if (loenW) m_lo <= wdataW;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_hi", hi, m_hi);
      cmp("model_lo", lo, m_lo);
      cmp("model_busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      cmp("model_stallD", {31'd0, stallD}, {31'd0, (m_left != 0) & (startE | hiuseD)});
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an op in the current cycle; returns in cycle 1 of the sequence
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    adv(1);
    startE = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_hi", hi, 32'h0);
    cmp("reset_lo", lo, 32'h0);
    cmp("reset_busy", {31'd0, busy}, 32'h0);
    cmp("reset_stallD", {31'd0, stallD}, 32'h0);
    adv(1);
    reset = 1'b0;
    adv(1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      cmp($sformatf("vec%0d_busy_c1", i), {31'd0, busy}, 32'h1);
      adv(32);
      @(negedge clk);
      cmp($sformatf("vec%0d_busy_c33", i), {31'd0, busy}, 32'h1);
      adv(1);
      @(negedge clk);
      cmp($sformatf("vec%0d_busy_c34", i), {31'd0, busy}, 32'h0);
      cmp($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      cmp($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // MFHI waiting in D from cycle 5: DIV 100/7 -> q=14, r=2
    issue(2'b10, 32'd100, 32'd7);
    adv(4);
    hiuseD = 1'b1;
    @(negedge clk);
    cmp("mfhi_stall_c5", {31'd0, stallD}, 32'h1);
    adv(28);
    @(negedge clk);
    cmp("mfhi_stall_c33", {31'd0, stallD}, 32'h1);
    adv(1);
    @(negedge clk);
    cmp("mfhi_stall_c34", {31'd0, stallD}, 32'h0);
    cmp("mfhi_hi_c34", hi, 32'd2);
    hiuseD = 1'b0;
    adv(1);

    // Back-to-back: second start held from cycle 2, results in cycle 68
    issue(2'b01, 32'd6, 32'd7);
    adv(1);
    startE = 1'b1;
    opE    = 2'b00;
    srcaE  = 32'hFFFFFFFE;
    srcbE  = 32'd5;
    @(negedge clk);
    cmp("b2b_stall_c2", {31'd0, stallD}, 32'h1);
    adv(31);
    @(negedge clk);
    cmp("b2b_stall_c33", {31'd0, stallD}, 32'h1);
    adv(1);
    @(negedge clk);
    cmp("b2b_stall_c34", {31'd0, stallD}, 32'h0);
    cmp("b2b_first_lo", lo, 32'd42);
    adv(1);
    startE = 1'b0;
    @(negedge clk);
    cmp("b2b_busy_c35", {31'd0, busy}, 32'h1);
    adv(33);
    @(negedge clk);
    cmp("b2b_hi_c68", hi, 32'hFFFFFFFF);
    cmp("b2b_lo_c68", lo, 32'hFFFFFFF6);
    adv(1);

    // Reset in cycle 10 of a sequence
    issue(2'b01, 32'd5, 32'd5);
    adv(9);
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    @(negedge clk);
    cmp("midrst_busy", {31'd0, busy}, 32'h0);
    cmp("midrst_hi", hi, 32'h0);
    cmp("midrst_lo", lo, 32'h0);
    adv(1);

    // MTHI in cycle 20 aborts DIVU 50/3; LO keeps 12 from MULTU 3*4
    issue(2'b01, 32'd3, 32'd4);
    adv(33);
    issue(2'b11, 32'd50, 32'd3);
    adv(19);
    hienW  = 1'b1;
    wdataW = 32'h12345678;
    adv(1);
    hienW = 1'b0;
    @(negedge clk);
    cmp("mthi_busy", {31'd0, busy}, 32'h0);
    cmp("mthi_hi", hi, 32'h12345678);
    cmp("mthi_lo", lo, 32'd12);
    adv(1);

    // MTLO on the same edge as FIX completion discards the product
    issue(2'b01, 32'd2, 32'd3);
    adv(32);
    loenW  = 1'b1;
    wdataW = 32'hAAAA5555;
    adv(1);
    loenW = 1'b0;
    @(negedge clk);
    cmp("fixw_busy", {31'd0, busy}, 32'h0);
    cmp("fixw_hi", hi, 32'h12345678);
    cmp("fixw_lo", lo, 32'hAAAA5555);
    adv(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
